// File: rtl/sram_access_ctrl_if.sv
// Request/response channel between a client and sram_access_ctrl.
// Handshake: a beat transfers on a posedge where valid && ready; the sender keeps valid and payload stable until it transfers, and ready may depend on the other side's ready, never on valid.
interface sram_access_ctrl_if #(
    parameter int AW = 16,
    parameter int DW = 23
);
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// Initiator-side controller for a 1-cycle-latency single-port SRAM with an in-order read response buffer.
// Define SRAM_INIT_EN to sweep the whole array to INIT_VALUE after every reset.
module sram_access_ctrl #(
    parameter int            DEPTH      = 65536,
    parameter int            AW         = 16,
    parameter int            DW         = 23,
    parameter int            RSP_DEPTH  = 2,
    parameter logic [DW-1:0] INIT_VALUE = '0
) (
    input  logic            clk,
    input  logic            rst,
    sram_access_ctrl_if.slave bus,
    output logic            init_busy,
    output logic            mem_cs_en,
    output logic            mem_wr_en,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wr_data,
    input  logic [DW-1:0]   mem_rd_data,
    output logic            dbg_state_o
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int OW = CW + 1;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

    state_e          state_q, state_d;
    logic            inflight_q, inflight_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]   buf_q [RSP_DEPTH];
    logic [AW-1:0]   sweep_addr;
    logic [OW-1:0]   occ;
    logic            push, pop, rd_fire, req_ready;

`ifdef SRAM_INIT_EN
    localparam state_e RESET_STATE = ST_INIT;
    logic [AW-1:0] sweep_q, sweep_d;

    always_comb begin
        sweep_d = sweep_q;
        if (state_q == ST_INIT) sweep_d = sweep_q + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) sweep_q <= '0;
        else     sweep_q <= sweep_d;
    end

    assign sweep_addr = sweep_q;
`else
    localparam state_e RESET_STATE = ST_RUN;
    assign sweep_addr = '0;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credits: buffered + in-flight reads, minus the entry leaving this cycle, must stay below RSP_DEPTH.
    assign pop  = bus.rsp_valid && bus.rsp_ready;
    assign push = inflight_q;
    assign occ  = OW'(count_q) + OW'(inflight_q) - OW'(pop);

    always_comb begin
        state_d     = state_q;
        init_busy   = 1'b0;
        req_ready   = 1'b0;
        mem_cs_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = bus.req_addr;
        mem_wr_data = bus.req_wdata;
        case (state_q)
            ST_INIT: begin
                init_busy   = 1'b1;
                mem_cs_en   = !rst;
                mem_wr_en   = !rst;
                mem_addr    = sweep_addr;
                mem_wr_data = INIT_VALUE;
                if (sweep_addr == AW'(DEPTH - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                req_ready = !rst && (occ < OW'(RSP_DEPTH));
                mem_cs_en = bus.req_valid && req_ready;
                mem_wr_en = mem_cs_en && bus.req_wr;
            end
            default: state_d = RESET_STATE;
        endcase
    end

    assign rd_fire        = mem_cs_en && !mem_wr_en;
    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = (count_q != '0);
    assign bus.rsp_rdata  = buf_q[rd_ptr_q];
    assign dbg_state_o    = state_q;

    always_comb begin
        inflight_d = rd_fire;
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // The SRAM presents read data the cycle after the strobe, which is exactly when inflight_q is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RSP_DEPTH; i++) buf_q[i] <= '0;
        end else if (push) begin
            buf_q[wr_ptr_q] <= mem_rd_data;
        end
    end
endmodule
